// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared types and the reference predictor for the 4-bit ALU response monitor.
//   opcode_bus_t           : 2-bit ALU opcode
//   alu_input_number_bus_t : 4-bit operand
//   alu_result_bus_t       : 5-bit result, bit 4 is carry/borrow
//   alu_mon_entry_t        : one in-flight prediction {opcode, a, b, expected}
//   alu_mon_rec_t          : captured failure {opcode, a, b, expected, actual}
//   mon_state_t            : monitor FSM state
//   alu_predict()          : golden ALU model, also usable by a scoreboard
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [1:0] {
        opcode_add        = 2'd0,
        opcode_sub        = 2'd1,
        opcode_not_a      = 2'd2,
        opcode_reduc_or_b = 2'd3
    } opcode_bus_t;

    typedef logic [3:0] alu_input_number_bus_t;
    typedef logic [4:0] alu_result_bus_t;

    typedef struct packed {
        opcode_bus_t           opcode;
        alu_input_number_bus_t a;
        alu_input_number_bus_t b;
        alu_result_bus_t       expected;
    } alu_mon_entry_t;

    typedef struct packed {
        opcode_bus_t           opcode;
        alu_input_number_bus_t a;
        alu_input_number_bus_t b;
        alu_result_bus_t       expected;
        alu_result_bus_t       actual;
    } alu_mon_rec_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        CHECK = 2'd2,
        HALT  = 2'd3
    } mon_state_t;

    // Subtraction wraps modulo 32 so bit 4 reads as the borrow.
    function automatic alu_result_bus_t alu_predict(
        input opcode_bus_t           op,
        input alu_input_number_bus_t a,
        input alu_input_number_bus_t b
    );
        case (op)
            opcode_add:   return {1'b0, a} + {1'b0, b};
            opcode_sub:   return {1'b0, a} - {1'b0, b};
            opcode_not_a: return {1'b0, ~a};
            default:      return {4'b0000, |b};
        endcase
    endfunction

endpackage

// File: rtl/alu_mon_pipe.sv
// ---------------------------------------------------------------------------
// alu_mon_pipe
// LATENCY-deep delay line carrying predicted ALU transactions with a valid
// bit per stage. flush clears every valid bit so stale entries never reach
// the head. LATENCY=0 is a pure wire from entry to head.
// Ports:
//   clk, reset_n  : clock, synchronous active-low reset (valid bits only)
//   flush         : clear all valid bits next edge
//   push          : valid for the entry presented this cycle
//   entry         : prediction entering stage 0
//   head_valid    : valid bit of the oldest stage
//   head          : oldest stage contents
// ---------------------------------------------------------------------------
module alu_mon_pipe
    import alu_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           flush,
    input  logic           push,
    input  alu_mon_entry_t entry,
    output logic           head_valid,
    output alu_mon_entry_t head
);

    generate
        if (LATENCY == 0) begin : g_bypass
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, reset_n, flush};
            assign head_valid  = push;
            assign head        = entry;
        end else begin : g_delay
            logic [LATENCY-1:0] vld_pn;
            alu_mon_entry_t     ent_pn [LATENCY];

            // ---- stage 0 .. LATENCY-1 : control (valid) ----
            always_ff @(posedge clk) begin
                if (!reset_n || flush) begin
                    vld_pn <= '0;
                end else begin
                    vld_pn[0] <= push;
                    for (int i = 1; i < LATENCY; i++) begin
                        vld_pn[i] <= vld_pn[i-1];
                    end
                end
            end

            // ---- stage 0 .. LATENCY-1 : data (no reset, qualified by valid) ----
            always_ff @(posedge clk) begin
                ent_pn[0] <= entry;
                for (int i = 1; i < LATENCY; i++) begin
                    ent_pn[i] <= ent_pn[i-1];
                end
            end

            assign head_valid = vld_pn[LATENCY-1];
            assign head       = ent_pn[LATENCY-1];
        end
    endgenerate

endmodule

// File: rtl/alu_response_monitor.sv
// ---------------------------------------------------------------------------
// alu_response_monitor
// Passive checker for a 4-bit ALU: predicts each transaction, delays the
// prediction by the ALU latency and compares it with the ALU result bus.
// Optional build macro: ALU_MON_STOP_ON_ERR_EN -- the first mismatch parks
// the FSM in HALT (no compares, counters frozen) until reset_n is asserted.
// Parameters:
//   LATENCY : ALU input-to-result latency in cycles, legal 0..4
//   CNT_W   : width of the saturating pass/error counters
// Ports:
//   clk, reset_n    : clock, synchronous active-low reset
//   enable          : arm checking; low flushes the pipeline and idles
//   opcode_bus,A,B  : stimulus presented to the ALU
//   result          : ALU output (bit 4 carry/borrow)
//   mismatch        : one-cycle pulse per failing compare
//   pass_count      : saturating count of passing compares
//   err_count       : saturating count of failing compares
//   first_err_valid : a failure has been captured since reset
//   first_err_info  : {opcode, A, B, expected, actual} of the first failure
//   state           : FSM state
// All outputs are registered and reflect the compare of the previous cycle.
// ---------------------------------------------------------------------------
module alu_response_monitor
    import alu_pkg::*;
#(
    parameter int LATENCY = 1,
    parameter int CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  opcode_bus_t           opcode_bus,
    input  alu_input_number_bus_t A,
    input  alu_input_number_bus_t B,
    input  alu_result_bus_t       result,
    output logic                  mismatch,
    output logic [CNT_W-1:0]      pass_count,
    output logic [CNT_W-1:0]      err_count,
    output logic                  first_err_valid,
    output alu_mon_rec_t          first_err_info,
    output mon_state_t            state
);

    // FILL lasts LATENCY cycles; the counter runs LATENCY-1 down to 0.
    localparam logic [2:0] FILL_LAST = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    alu_mon_entry_t in_entry;
    alu_mon_entry_t head;
    logic           head_valid;
    logic           compare_en;
    logic           is_err;
    logic [2:0]     fill_cnt;

    // ---- p0 : predict at the ALU inputs ----
    assign in_entry = '{opcode:   opcode_bus,
                        a:        A,
                        b:        B,
                        expected: alu_predict(opcode_bus, A, B)};

    alu_mon_pipe #(
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (!enable),
        .push       (enable),
        .entry      (in_entry),
        .head_valid (head_valid),
        .head       (head)
    );

    // ---- pLATENCY : compare head against the result bus ----
    // A cycle with enable low is a flush cycle: the head belongs to the
    // stream being abandoned, so it is not compared.
    assign compare_en = (state == CHECK) && enable && head_valid;
    // Case inequality so an X/Z on the result bus counts as a failure.
    assign is_err     = (result !== head.expected);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= IDLE;
            fill_cnt        <= '0;
            mismatch        <= 1'b0;
            pass_count      <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_info  <= '0;
        end else begin
            mismatch <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state    <= (LATENCY == 0) ? CHECK : FILL;
                        fill_cnt <= FILL_LAST;
                    end
                end
                FILL: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (fill_cnt == '0) begin
                        state <= CHECK;
                    end else begin
                        fill_cnt <= fill_cnt - 3'd1;
                    end
                end
                CHECK: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (compare_en) begin
                        if (is_err) begin
                            mismatch  <= 1'b1;
                            err_count <= sat_inc(err_count);
                            if (!first_err_valid) begin
                                first_err_valid <= 1'b1;
                                first_err_info  <= '{opcode:   head.opcode,
                                                     a:        head.a,
                                                     b:        head.b,
                                                     expected: head.expected,
                                                     actual:   result};
                            end
`ifdef ALU_MON_STOP_ON_ERR_EN
                            state <= HALT;
`endif
                        end else begin
                            pass_count <= sat_inc(pass_count);
                        end
                    end
                end
`ifdef ALU_MON_STOP_ON_ERR_EN
                // Terminal until reset; enable is deliberately ignored.
                HALT: state <= HALT;
`else
                HALT: state <= IDLE;
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_response_monitor.sv
// ---------------------------------------------------------------------------
// tb_alu_response_monitor
// Self-checking bench for alu_response_monitor. The bench plays the ALU with
// LATENCY=1: inputs of vector k and the result of vector k-1 are driven in
// the same cycle. dut uses CNT_W=8, dut_s uses CNT_W=2 for saturation.
// Honours ALU_MON_STOP_ON_ERR_EN when defined.
// ---------------------------------------------------------------------------
module tb_alu_response_monitor;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  reset_n, enable, reset_n2, enable2;
    opcode_bus_t           opcode_bus;
    alu_input_number_bus_t a_in, b_in;
    alu_result_bus_t       result;

    logic         mismatch, first_err_valid;
    logic [7:0]   pass_count, err_count;
    alu_mon_rec_t first_err_info;
    mon_state_t   state;

    logic         mismatch2, first_err_valid2;
    logic [1:0]   pass_count2, err_count2;
    alu_mon_rec_t first_err_info2;
    mon_state_t   state2;

    alu_response_monitor #(.LATENCY(1), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .opcode_bus(opcode_bus), .A(a_in), .B(b_in), .result(result),
        .mismatch(mismatch), .pass_count(pass_count), .err_count(err_count),
        .first_err_valid(first_err_valid), .first_err_info(first_err_info),
        .state(state)
    );

    alu_response_monitor #(.LATENCY(1), .CNT_W(2)) dut_s (
        .clk(clk), .reset_n(reset_n2), .enable(enable2),
        .opcode_bus(opcode_bus), .A(a_in), .B(b_in), .result(result),
        .mismatch(mismatch2), .pass_count(pass_count2), .err_count(err_count2),
        .first_err_valid(first_err_valid2), .first_err_info(first_err_info2),
        .state(state2)
    );

    typedef struct {
        opcode_bus_t     op;
        logic [3:0]      a;
        logic [3:0]      b;
        alu_result_bus_t drive;   // what the "ALU" returns
        alu_result_bus_t exp;     // hand-computed correct result
    } vec_t;

    typedef struct {
        logic         mis;
        logic [7:0]   pcnt;
        logic [7:0]   ecnt;
        logic         fv;
        alu_mon_rec_t info;
    } exp_t;

    localparam int NV = 10;
    vec_t vecs [NV];
    exp_t sbq [$];
    exp_t ex, e;

    int n_checks = 0;
    int n_pass   = 0;

    int           m_pass, m_err;
    logic         m_fv, m_halt;
    alu_mon_rec_t m_info;
    int           e2, pulses;
    logic         h2, exp_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{opcode_add,        4'd7,  4'd9, 5'd16, 5'd16};
        vecs[1] = '{opcode_sub,        4'd3,  4'd5, 5'd30, 5'd30};
        vecs[2] = '{opcode_not_a,      4'd10, 4'd0, 5'd5,  5'd5};
        vecs[3] = '{opcode_reduc_or_b, 4'd0,  4'd0, 5'd1,  5'd0};
        vecs[4] = '{opcode_add,        4'd15, 4'd15, 5'd0, 5'd30};
        vecs[5] = '{opcode_sub,        4'd0,  4'd1, 5'd3,  5'd31};
        vecs[6] = '{opcode_add,        4'd15, 4'd1, 5'd16, 5'd16};
        vecs[7] = '{opcode_reduc_or_b, 4'd5,  4'd8, 5'd1,  5'd1};
        vecs[8] = '{opcode_sub,        4'd9,  4'd9, 5'd0,  5'd0};
        vecs[9] = '{opcode_not_a,      4'd0,  4'd3, 5'd15, 5'd15};

        m_pass = 0; m_err = 0; m_fv = 1'b0; m_halt = 1'b0; m_info = '0;

        reset_n = 1'b0; enable = 1'b0; reset_n2 = 1'b0; enable2 = 1'b0;
        opcode_bus = opcode_add; a_in = 4'd0; b_in = 4'd0; result = 5'd0;
        repeat (3) step();
        check("rst_mismatch",  32'(mismatch),        32'(0));
        check("rst_pass",      32'(pass_count),      32'(0));
        check("rst_err",       32'(err_count),       32'(0));
        check("rst_first_vld", 32'(first_err_valid), 32'(0));
        check("rst_first_inf", 32'(first_err_info),  32'(0));
        check("rst_state",     32'(state),           32'(IDLE));

        reset_n = 1'b1; reset_n2 = 1'b1;
        step();
        check("idle_hold", 32'(state), 32'(IDLE));

        // Arming cycle: its entry reaches the head during FILL and is never compared.
        enable = 1'b1;
        result = 5'd31;
        step();
        check("fill_entry", 32'(state), 32'(FILL));

        for (int k = 0; k <= NV; k++) begin
            if (k < NV) begin
                opcode_bus = vecs[k].op; a_in = vecs[k].a; b_in = vecs[k].b;
                ex.mis = 1'b0;
                if (!m_halt) begin
                    if (vecs[k].drive != vecs[k].exp) begin
                        ex.mis = 1'b1;
                        m_err++;
                        if (!m_fv) begin
                            m_fv   = 1'b1;
                            m_info = '{vecs[k].op, vecs[k].a, vecs[k].b, vecs[k].exp, vecs[k].drive};
                        end
`ifdef ALU_MON_STOP_ON_ERR_EN
                        m_halt = 1'b1;
`endif
                    end else begin
                        m_pass++;
                    end
                end
                ex.pcnt = 8'(m_pass); ex.ecnt = 8'(m_err); ex.fv = m_fv; ex.info = m_info;
                sbq.push_back(ex);
            end else begin
                opcode_bus = opcode_add; a_in = 4'd2; b_in = 4'd2;
            end
            if (k > 0) result = vecs[k-1].drive;
            step();
            if (k == 0) begin
                check("check_entry", 32'(state), 32'(CHECK));
            end else if (sbq.size() == 0) begin
                check("sb_underflow", 32'(1), 32'(0));
            end else begin
                e = sbq.pop_front();
                check($sformatf("v%0d_mismatch", k-1), 32'(mismatch),        32'(e.mis));
                check($sformatf("v%0d_pass", k-1),     32'(pass_count),      32'(e.pcnt));
                check($sformatf("v%0d_err", k-1),      32'(err_count),       32'(e.ecnt));
                check($sformatf("v%0d_first_vld", k-1),32'(first_err_valid), 32'(e.fv));
                check($sformatf("v%0d_first_inf", k-1),32'(first_err_info),  32'(e.info));
            end
        end
        check("first_inf_const", 32'(first_err_info), 32'(20'hC0001));

`ifdef ALU_MON_STOP_ON_ERR_EN
        check("halt_state", 32'(state),      32'(HALT));
        check("halt_err",   32'(err_count),  32'(1));
        check("halt_pass",  32'(pass_count), 32'(3));
        enable = 1'b0; result = 5'd31;
        step();
        check("halt_ignores_enable", 32'(state), 32'(HALT));
        enable = 1'b1; reset_n = 1'b0;
        step();
        check("halt_reset_state", 32'(state),     32'(IDLE));
        check("halt_reset_err",   32'(err_count), 32'(0));
        reset_n = 1'b1; enable = 1'b0;
        step();
`else
        check("no_halt_state", 32'(state), 32'(CHECK));
        // Drop enable for one cycle; head holds ADD(2,2) and a wrong result is on the bus.
        enable = 1'b0; opcode_bus = opcode_add; a_in = 4'd1; b_in = 4'd1; result = 5'd31;
        step();
        check("drop_state",    32'(state),     32'(IDLE));
        check("drop_mismatch", 32'(mismatch),  32'(0));
        check("drop_err",      32'(err_count), 32'(m_err));
        enable = 1'b1; a_in = 4'd1; b_in = 4'd2;
        step();
        check("rearm_state", 32'(state),    32'(FILL));
        check("rearm_mis",   32'(mismatch), 32'(0));
        a_in = 4'd4; b_in = 4'd4;
        step();
        check("refill_state", 32'(state),      32'(CHECK));
        check("refill_err",   32'(err_count),  32'(m_err));
        check("refill_pass",  32'(pass_count), 32'(m_pass));
        a_in = 4'd0; b_in = 4'd0; result = 5'd8;
        step();
        check("resume_pass", 32'(pass_count), 32'(m_pass + 1));
        check("resume_mis",  32'(mismatch),   32'(0));
        check("resume_err",  32'(err_count),  32'(m_err));
        enable = 1'b0;
        step();
        check("off_state", 32'(state),     32'(IDLE));
        check("off_err",   32'(err_count), 32'(m_err));
`endif

        // Saturation on the 2-bit instance: repeated OR-reduce(0) answered with 1.
        enable = 1'b0;
        e2 = 0; h2 = 1'b0; pulses = 0;
        enable2 = 1'b1; opcode_bus = opcode_reduc_or_b; a_in = 4'd0; b_in = 4'd0; result = 5'd0;
        step();
        check("s_fill", 32'(state2), 32'(FILL));
        for (int k = 0; k <= 5; k++) begin
            result = (k == 0) ? 5'd0 : 5'd1;
            step();
            if (k > 0) begin
                exp_m = !h2;
                if (!h2) e2 = (e2 < 3) ? e2 + 1 : 3;
`ifdef ALU_MON_STOP_ON_ERR_EN
                h2 = 1'b1;
`endif
                check($sformatf("s%0d_mismatch", k), 32'(mismatch2),  32'(exp_m));
                check($sformatf("s%0d_err", k),      32'(err_count2), 32'(e2));
                pulses += int'(mismatch2);
            end
        end
`ifdef ALU_MON_STOP_ON_ERR_EN
        check("s_pulses", 32'(pulses), 32'(1));
`else
        check("s_pulses", 32'(pulses), 32'(5));
`endif
        check("s_pass", 32'(pass_count2), 32'(0));
        check("s_first_inf", 32'(first_err_info2), 32'(20'hC0001));

        reset_n2 = 1'b0;
        step();
        check("s_rst_state", 32'(state2),           32'(IDLE));
        check("s_rst_mis",   32'(mismatch2),        32'(0));
        check("s_rst_err",   32'(err_count2),       32'(0));
        check("s_rst_pass",  32'(pass_count2),      32'(0));
        check("s_rst_fv",    32'(first_err_valid2), 32'(0));
        check("s_rst_inf",   32'(first_err_info2),  32'(0));
        reset_n2 = 1'b1; enable2 = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_response_monitor.md
Name: alu_response_monitor

Overview:
- Passive checker on the far side of the 4-bit ALU stimulus interface.
- Samples the opcode and operands driven into the ALU, predicts the result through a LATENCY-deep pipeline, and compares it with the ALU result bus.
- Counts passes and errors, flags each mismatch, and captures the first failing transaction for the bench.
- Synthesizable, so it can sit in the testbench or be bound next to the ALU.

Parameters:
- LATENCY, 1, ALU input-to-result latency in clk cycles; legal 0..4.
- CNT_W, 8, width of the pass and error counters.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset_n  input  1  synchronous, active-low reset.
- enable  input  1  arm checking; 0 flushes the pipeline and idles.
- opcode_bus  input  opcode_bus_t (2)  opcode presented to the ALU.
- A  input  alu_input_number_bus_t (4)  operand A presented to the ALU.
- B  input  alu_input_number_bus_t (4)  operand B presented to the ALU.
- result  input  alu_result_bus_t (5)  ALU output; bit 4 is carry/borrow.
- mismatch  output  1  one-cycle pulse on a compare failure.
- pass_count  output  CNT_W  saturating count of passing compares.
- err_count  output  CNT_W  saturating count of failing compares.
- first_err_valid  output  1  set on the first mismatch since reset.
- first_err_info  output  alu_mon_rec_t (20)  {opcode, A, B, expected, actual} of the first mismatch.
- state  output  mon_state_t (2)  current FSM state.

Behaviour:
- Reset: synchronous on posedge clk when reset_n=0. All outputs go to 0, state goes to IDLE, and pipeline valid bits are cleared. Reset overrides every other input, including mid-check.
- Expected result (5-bit):
  - opcode_add (0): {1'b0,A}+{1'b0,B}
  - opcode_sub (1): ({1'b0,A}-{1'b0,B}) mod 32
  - opcode_not_a (2): {1'b0,~A}
  - opcode_reduc_or_b (3): {4'b0,|B}
- Pipeline:
  - Each cycle with enable=1, {opcode,A,B,expected} is pushed with valid=1 into a LATENCY-stage shift register.
  - The stage LATENCY output is compared against `result` in the same cycle.
  - For LATENCY=0, the compare is against the current inputs with no registers.
- FSM:
  - IDLE: wait for enable=1, then go to FILL. If LATENCY=0, go straight to CHECK.
  - FILL: count LATENCY cycles, then go to CHECK. No compares are made in FILL.
  - CHECK: compare every cycle where the head entry is valid.
  - HALT: only reachable with the optional feature.
  - In any state, enable=0 returns to IDLE next cycle and clears all valid bits. Counters and first_err are retained.
- Compare outcomes:
  - Equal: pass_count+1.
  - Not equal: err_count+1, and mismatch=1 for exactly that cycle. If first_err_valid=0, capture first_err_info and set first_err_valid.
- Saturation: counters stop at 2^CNT_W-1 and never wrap. mismatch still pulses while err_count is saturated.
- enable toggling: enable re-asserted after a drop restarts FILL; stale entries are never compared.
- X handling: an X on `result` in CHECK counts as a mismatch, using `!==`-equivalent compare semantics in simulation.

Optional Feature:
- Macro: ALU_MON_STOP_ON_ERR_EN.
- Defined:
  - The first mismatch moves CHECK to HALT.
  - HALT performs no compares, freezes both counters, and holds mismatch=0.
  - HALT exits only via reset_n=0.
  - enable is ignored in HALT.
- Undefined: HALT is not generated, and checking continues through errors.

Decomposition:
- Package alu_pkg holds:
  - opcode_bus_t and its enum values (opcode_add=0, opcode_sub=1, opcode_not_a=2, opcode_reduc_or_b=3)
  - alu_input_number_bus_t (logic [3:0])
  - alu_result_bus_t (logic [4:0])
  - alu_mon_rec_t (packed struct)
  - mon_state_t {IDLE, FILL, CHECK, HALT}
- The predictor function `alu_predict` also lives in the package, shared with the scoreboard.
- One sub-module: alu_mon_pipe (parameterized LATENCY delay line with valid bits and flush).

Test Plan:
- LATENCY=1. Enable, then ADD(7,9) with result=16 one cycle later -> pass_count=1, mismatch never asserted.
- SUB(3,5) expecting 30, and NOT_A(10) expecting 5 -> both pass. Then ReductionOrB(0) with result=1 -> mismatch pulse, err_count=1, first_err_info={3,0,0,0,1}.
- Two mismatches in a row -> err_count=2, and first_err_info still holds the first.
- enable drops for 1 cycle mid-stream, then re-asserts -> FILL lasts 1 cycle; no compare occurs on the entry pushed before the drop.
- CNT_W=2 with 5 errors -> err_count stays at 3, mismatch pulses 5 times. Then reset_n=0 for 1 cycle -> all outputs 0 and state=IDLE.
- With ALU_MON_STOP_ON_ERR_EN and one error followed by 3 correct results -> state=HALT, pass_count unchanged after the error, err_count=1.
